// File: rtl/ccc_seq_pkg.sv
// Shared types and defaults for the CCC lock sequencer: state encoding,
// parameter defaults and the counter widths derived from them.
package ccc_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_APPLY     = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  localparam int STATE_W           = 3;
  localparam int DEF_DIV_W         = 5;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_LOCK_STABLE   = 64;
  localparam int DEF_LOCK_TIMEOUT  = 4096;
  localparam int DEF_MAX_RETRY     = 3;
  localparam int DEF_RESET_DIV     = 0;

  // Counters are sized to hold their terminal value so they can saturate on it.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int DEF_SETTLE_W = cnt_w(DEF_SETTLE_CYCLES);
  localparam int DEF_STABLE_W = cnt_w(DEF_LOCK_STABLE);
  localparam int DEF_TMO_W    = cnt_w(DEF_LOCK_TIMEOUT);
  localparam int DEF_RETRY_W  = cnt_w(DEF_MAX_RETRY);

endpackage

// File: rtl/ccc_lock_sequencer_sync2.sv
// Two-flop synchroniser for asynchronous level inputs; resets to 0 so a
// synchronised lock never reads as asserted during or just after reset.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ccc_lock_sequencer.sv
// Applies CCC divider settings, waits for PLL lock (or a fixed settle in bypass),
// releases the fabric reset, and re-sequences on lock loss with bounded retries.
module ccc_lock_sequencer
  import ccc_seq_pkg::*;
#(
  parameter int DIV_W         = DEF_DIV_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int LOCK_STABLE   = DEF_LOCK_STABLE,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int MAX_RETRY     = DEF_MAX_RETRY,
  parameter int RESET_DIV     = DEF_RESET_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lock_in,
  input  logic             bypass,
  input  logic             cfg_req,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic [DIV_W-1:0] oadiv,
  output logic             fab_rst_n,
  output logic             ready,
  output logic             fault,
  output logic [1:0]       retry_cnt,
  output logic [2:0]       state_o
);

  localparam int SET_W = cnt_w(SETTLE_CYCLES);
  localparam int STB_W = cnt_w(LOCK_STABLE);
  localparam int TMO_W = cnt_w(LOCK_TIMEOUT);
  localparam int RTY_W = cnt_w(MAX_RETRY);

  localparam logic [SET_W-1:0] SET_MAX  = SET_W'(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(LOCK_STABLE);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(LOCK_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);
  localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(RESET_DIV);

  state_e           state_q, state_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [DIV_W-1:0] oadiv_q, oadiv_d;
  logic             fab_rst_n_q, fab_rst_n_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             req_pend_q, pend_d;
  logic             req_armed_q, armed_d;
  logic             accept, enter_done, req_new;
  logic             lock_s, bypass_s, lock_eff;

  sync2 #(.WIDTH(2)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({bypass, lock_in}),
    .q     ({bypass_s, lock_s})
  );

  assign lock_eff = bypass_s | lock_s;
  // A request is only new once cfg_req has been seen low since the last accept.
  assign req_new  = cfg_req & req_armed_q;

  always_comb begin
    state_d     = state_q;
    set_cnt_d   = set_cnt_q;
    stb_cnt_d   = stb_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    retry_d     = retry_q;
    oadiv_d     = oadiv_q;
    pend_d      = req_pend_q;
    armed_d     = req_armed_q | ~cfg_req;
    accept      = 1'b0;
    enter_done  = 1'b0;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    fab_rst_n_d = 1'b0;

    case (state_q)
      ST_HOLD, ST_APPLY: state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (set_cnt_q >= SET_LAST) state_d = ST_WAIT_LOCK;
        else set_cnt_d = (set_cnt_q == SET_MAX) ? SET_MAX : set_cnt_q + 1'b1;
      end
      ST_WAIT_LOCK: begin
        stb_cnt_d = !lock_eff ? '0 :
                    (stb_cnt_q == STB_MAX) ? STB_MAX : stb_cnt_q + 1'b1;
        tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? TMO_MAX : tmo_cnt_q + 1'b1;
        // Reaching stable lock takes priority over a coincident timeout.
        if (lock_eff && stb_cnt_q >= STB_LAST) begin
          state_d = ST_RUN;
        end else if (tmo_cnt_q >= TMO_LAST) begin
          retry_d = (retry_q == RTY_MAX) ? RTY_MAX : retry_q + 1'b1;
          state_d = (retry_q >= RTY_LAST) ? ST_FAULT : ST_SETTLE;
        end
      end
      ST_RUN: begin
        if (req_new) accept = 1'b1;
        else if (!lock_eff) state_d = ST_SETTLE;
      end
      ST_FAULT: begin
        if (req_new) accept = 1'b1;
      end
      default: state_d = ST_HOLD;
    endcase

    if (accept) begin
      state_d = ST_APPLY;
      oadiv_d = cfg_div;
      pend_d  = 1'b1;
      armed_d = 1'b0;
      retry_d = '0;
    end

    if (state_d != state_q) begin
      set_cnt_d = '0;
      stb_cnt_d = '0;
      tmo_cnt_d = '0;
    end

    if (state_d == ST_RUN && state_q != ST_RUN) retry_d = '0;

    enter_done  = (state_d != state_q) && (state_d == ST_RUN || state_d == ST_FAULT);
    ack_d       = enter_done && req_pend_q;
    err_d       = ack_d && (state_d == ST_FAULT);
    if (ack_d) pend_d = 1'b0;
    fab_rst_n_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HOLD;
      set_cnt_q   <= '0;
      stb_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      retry_q     <= '0;
      oadiv_q     <= RST_DIV;
      fab_rst_n_q <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      req_pend_q  <= 1'b0;
      req_armed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      set_cnt_q   <= set_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      retry_q     <= retry_d;
      oadiv_q     <= oadiv_d;
      fab_rst_n_q <= fab_rst_n_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      req_pend_q  <= pend_d;
      req_armed_q <= armed_d;
    end
  end

  assign oadiv     = oadiv_q;
  assign fab_rst_n = fab_rst_n_q;
  assign cfg_ack   = ack_q;
  assign cfg_err   = err_q;
  assign ready     = (state_q == ST_RUN);
  assign fault     = (state_q == ST_FAULT);
  assign retry_cnt = 2'(retry_q);
  assign state_o   = state_q;

endmodule

// File: tb/tb_ccc_lock_sequencer.sv
// Bench for ccc_lock_sequencer: random lock/request timing against closed-form
// expectations of when RUN, timeouts, FAULT and acknowledges must occur.
module tb_ccc_lock_sequencer;

  localparam int SETTLE = 16;
  localparam int STABLE = 64;
  localparam int TMO    = 4096;
  localparam logic [2:0] S_HOLD = 3'd0, S_APPLY = 3'd1, S_SETTLE = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3, S_RUN = 3'd4, S_FAULT = 3'd5;

  logic clk = 1'b0, rst_n = 1'b0, lock_in = 1'b0, bypass = 1'b0, cfg_req = 1'b0;
  logic [4:0] cfg_div = '0;
  logic cfg_ack, cfg_err, fab_rst_n, ready, fault;
  logic [4:0] oadiv;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;
  int cyc = 0, ack_cnt = 0, errors = 0, checks = 0;
  logic [4:0] exp_div = '0;

  ccc_lock_sequencer dut (
    .clk(clk), .rst_n(rst_n), .lock_in(lock_in), .bypass(bypass),
    .cfg_req(cfg_req), .cfg_div(cfg_div), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .oadiv(oadiv), .fab_rst_n(fab_rst_n), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && cfg_ack) ack_cnt <= ack_cnt + 1;

  // Sequence started by the edge after `start`; lock driven high after edge lock_edge
  // becomes visible to the sequencer three edges later; RUN needs STABLE locked WAIT edges.
  function automatic int exp_run(input int start, input int lock_edge);
    int seen = lock_edge + 3;
    int first_wait = start + SETTLE + 2;
    return ((seen > first_wait) ? seen : first_wait) + STABLE - 1;
  endfunction

  function automatic int exp_timeout(input int start, input int k);
    return start + 1 + k * (SETTLE + TMO);
  endfunction

  task automatic do_reset(output int start);
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; start = cyc;
  endtask

  task automatic wait_state(input logic [2:0] st, input int bound, output int e);
    e = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (state_o === st) begin e = cyc; return; end
    end
  endtask

  task automatic wait_retry(input logic [1:0] v, input int bound, output int e);
    e = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (retry_cnt === v) begin e = cyc; return; end
    end
  endtask

  task automatic wait_ack(input int bound, output int e, output logic err);
    e = -1; err = 1'bx;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (cfg_ack === 1'b1) begin e = cyc; err = cfg_err; return; end
    end
  endtask

  task automatic test_reset();
    int start;
    bypass = 1'b1; lock_in = 1'b0; cfg_req = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({state_o, oadiv, fab_rst_n, ready, fault, cfg_ack, cfg_err, retry_cnt} !== 15'd0) begin
      errors++; $display("FAIL reset_outputs: got %b required all zero", {state_o, oadiv, fab_rst_n, ready, fault, cfg_ack, cfg_err, retry_cnt});
    end
    rst_n = 1'b1; start = cyc;
    @(negedge clk);
    checks++; if (state_o !== S_SETTLE || fab_rst_n !== 1'b0) begin
      errors++; $display("FAIL hold_to_settle: state %0d fab_rst_n %b required %0d 0", state_o, fab_rst_n, S_SETTLE);
    end
  endtask

  task automatic test_bypass_powerup();
    int start, e;
    bypass = 1'b1; lock_in = 1'b0;
    do_reset(start);
    wait_state(S_RUN, 300, e);
    checks++; if (e !== exp_run(start, start - 1000)) begin
      errors++; $display("FAIL bypass_run_cycle: got %0d required %0d", e - start, exp_run(start, start - 1000) - start);
    end
    checks++; if (fab_rst_n !== 1'b1 || ready !== 1'b1 || oadiv !== 5'd0) begin
      errors++; $display("FAIL bypass_run_outputs: fab_rst_n %b ready %b oadiv %0d required 1 1 0", fab_rst_n, ready, oadiv);
    end
  endtask

  task automatic test_pll_lock();
    int start, e, d, le, n0;
    for (int t = 0; t < 3; t++) begin
      bypass = 1'b0; lock_in = 1'b0;
      do_reset(start);
      n0 = ack_cnt;
      d = (t == 0) ? 100 : int'($urandom_range(0, 250));
      repeat (d) @(negedge clk);
      lock_in = 1'b1; le = cyc;
      wait_state(S_RUN, 700, e);
      checks++; if (e !== exp_run(start, le)) begin
        errors++; $display("FAIL pll_run_cycle[%0d]: got %0d required %0d (lock at %0d)", t, e - start, exp_run(start, le) - start, le - start);
      end
      @(negedge clk);
      checks++; if (retry_cnt !== 2'd0 || fab_rst_n !== 1'b1 || ack_cnt !== n0) begin
        errors++; $display("FAIL pll_run_state[%0d]: retry %0d fab %b acks %0d required 0 1 %0d", t, retry_cnt, fab_rst_n, ack_cnt, n0);
      end
    end
    exp_div = 5'd0;
  endtask

  task automatic test_back_to_back();
    int a, e, n0;
    logic err;
    logic [4:0] d;
    for (int i = 0; i < 3; i++) begin
      d = (i == 0) ? 5'h03 : 5'($urandom_range(1, 31));
      @(negedge clk); cfg_req = 1'b1; cfg_div = d; a = cyc + 1;
      @(negedge clk);
      exp_div = d;
      checks++; if (state_o !== S_APPLY || oadiv !== exp_div || fab_rst_n !== 1'b0 || ready !== 1'b0) begin
        errors++; $display("FAIL apply[%0d]: state %0d oadiv %0d fab %b ready %b required %0d %0d 0 0", i, state_o, oadiv, fab_rst_n, ready, S_APPLY, exp_div);
      end
      wait_ack(300, e, err);
      checks++; if (e !== exp_run(a, a - 1000) || err !== 1'b0 || ready !== 1'b1) begin
        errors++; $display("FAIL reconfig_ack[%0d]: at %0d err %b ready %b required %0d 0 1", i, e - a, err, ready, exp_run(a, a - 1000) - a);
      end
      @(negedge clk); n0 = ack_cnt;
      repeat (30) @(negedge clk);
      checks++; if (ack_cnt !== n0 || state_o !== S_RUN || oadiv !== exp_div) begin
        errors++; $display("FAIL held_req[%0d]: acks %0d state %0d oadiv %0d required %0d %0d %0d", i, ack_cnt, state_o, oadiv, n0, S_RUN, exp_div);
      end
      @(negedge clk); cfg_req = 1'b0;
    end
  endtask

  task automatic test_lock_glitch();
    int g, e, n0;
    repeat ($urandom_range(5, 40)) @(negedge clk);
    n0 = ack_cnt;
    @(negedge clk); lock_in = 1'b0; g = cyc;
    @(negedge clk); lock_in = 1'b1;
    @(negedge clk);
    checks++; if (fab_rst_n !== 1'b1) begin
      errors++; $display("FAIL glitch_early: fab_rst_n %b required 1", fab_rst_n);
    end
    @(negedge clk);
    checks++; if (fab_rst_n !== 1'b0 || state_o !== S_SETTLE) begin
      errors++; $display("FAIL glitch_drop: fab_rst_n %b state %0d required 0 %0d", fab_rst_n, state_o, S_SETTLE);
    end
    wait_state(S_RUN, 300, e);
    checks++; if (e !== exp_run(g + 2, g + 1)) begin
      errors++; $display("FAIL glitch_relock: got %0d required %0d", e - g, exp_run(g + 2, g + 1) - g);
    end
    @(negedge clk);
    checks++; if (ack_cnt !== n0 || retry_cnt !== 2'd0 || oadiv !== exp_div) begin
      errors++; $display("FAIL glitch_side: acks %0d retry %0d oadiv %0d required %0d 0 %0d", ack_cnt, retry_cnt, oadiv, n0, exp_div);
    end
  endtask

  task automatic test_pending_request();
    int start, e;
    logic err;
    logic [4:0] d;
    bypass = 1'b0; lock_in = 1'b1; cfg_req = 1'b0;
    do_reset(start);
    repeat (5) @(negedge clk);
    d = 5'($urandom_range(1, 31));
    cfg_req = 1'b1; cfg_div = d;
    @(negedge clk);
    checks++; if (state_o !== S_SETTLE || oadiv !== 5'd0) begin
      errors++; $display("FAIL pending_wait: state %0d oadiv %0d required %0d 0", state_o, oadiv, S_SETTLE);
    end
    wait_state(S_APPLY, 300, e);
    checks++; if (e !== exp_run(start, start) + 1 || oadiv !== d) begin
      errors++; $display("FAIL pending_accept: at %0d oadiv %0d required %0d %0d", e - start, oadiv, exp_run(start, start) + 1 - start, d);
    end
    exp_div = d;
    wait_ack(300, e, err);
    checks++; if (e !== exp_run(start, start) + 1 + exp_run(0, -1000) || err !== 1'b0) begin
      errors++; $display("FAIL pending_ack: at %0d err %b required %0d 0", e - start, err, exp_run(start, start) + 1 + exp_run(0, -1000) - start);
    end
    @(negedge clk); cfg_req = 1'b0;
  endtask

  task automatic test_async_reset();
    int e, start;
    @(negedge clk); cfg_req = 1'b1; cfg_div = 5'h1b;
    wait_state(S_WAIT, 100, e);
    cfg_req = 1'b0;
    checks++; if (e < 0 || oadiv !== 5'h1b) begin
      errors++; $display("FAIL async_setup: wait edge %0d oadiv %0d required >=0 27", e, oadiv);
    end
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({state_o, oadiv, fab_rst_n, ready, fault, cfg_ack, cfg_err, retry_cnt} !== 15'd0) begin
      errors++; $display("FAIL async_reset: got %b required all zero", {state_o, oadiv, fab_rst_n, ready, fault, cfg_ack, cfg_err, retry_cnt});
    end
    do_reset(start);
    exp_div = 5'd0;
  endtask

  task automatic test_timeout_fault();
    int start, e, a, n0;
    logic err;
    logic [4:0] d;
    bypass = 1'b0; lock_in = 1'b0; cfg_req = 1'b0;
    do_reset(start);
    n0 = ack_cnt;
    for (int k = 1; k <= 2; k++) begin
      wait_retry(2'(k), 5000, e);
      checks++; if (e !== exp_timeout(start, k) || state_o !== S_SETTLE) begin
        errors++; $display("FAIL timeout_%0d: at %0d state %0d required %0d %0d", k, e - start, state_o, exp_timeout(start, k) - start, S_SETTLE);
      end
    end
    wait_state(S_FAULT, 5000, e);
    checks++; if (e !== exp_timeout(start, 3) || fault !== 1'b1 || ready !== 1'b0 || fab_rst_n !== 1'b0 || retry_cnt !== 2'd3) begin
      errors++; $display("FAIL fault_entry: at %0d fault %b ready %b fab %b retry %0d required %0d 1 0 0 3", e - start, fault, ready, fab_rst_n, retry_cnt, exp_timeout(start, 3) - start);
    end
    @(negedge clk);
    checks++; if (ack_cnt !== n0) begin
      errors++; $display("FAIL fault_no_ack: acks %0d required %0d", ack_cnt, n0);
    end
    d = 5'($urandom_range(1, 31));
    cfg_req = 1'b1; cfg_div = d; a = cyc + 1;
    @(negedge clk);
    checks++; if (state_o !== S_APPLY || retry_cnt !== 2'd0 || oadiv !== d || fault !== 1'b0) begin
      errors++; $display("FAIL fault_exit: state %0d retry %0d oadiv %0d fault %b required %0d 0 %0d 0", state_o, retry_cnt, oadiv, fault, S_APPLY, d);
    end
    wait_ack(14000, e, err);
    checks++; if (e !== exp_timeout(a, 3) || err !== 1'b1 || fault !== 1'b1) begin
      errors++; $display("FAIL fault_ack: at %0d err %b fault %b required %0d 1 1", e - a, err, fault, exp_timeout(a, 3) - a);
    end
    @(negedge clk); n0 = ack_cnt;
    repeat (10) @(negedge clk);
    checks++; if (state_o !== S_FAULT || ack_cnt !== n0) begin
      errors++; $display("FAIL fault_held_req: state %0d acks %0d required %0d %0d", state_o, ack_cnt, S_FAULT, n0);
    end
    cfg_req = 1'b0;
    @(negedge clk); lock_in = 1'b1; cfg_req = 1'b1; a = cyc + 1;
    wait_ack(300, e, err);
    checks++; if (e !== exp_run(a, a - 1) || err !== 1'b0 || ready !== 1'b1 || retry_cnt !== 2'd0) begin
      errors++; $display("FAIL fault_recover: at %0d err %b ready %b retry %0d required %0d 0 1 0", e - a, err, ready, retry_cnt, exp_run(a, a - 1) - a);
    end
    cfg_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bypass_powerup();
    test_pll_lock();
    test_back_to_back();
    test_lock_glitch();
    test_pending_request();
    test_async_reset();
    test_timeout_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
